// File: rtl/keypad_scanner.sv
// Scans a 4x3 active-low matrix keypad, debounces press and release, and reports
// each accepted key once as a 4-bit code followed by a fixed-width strobe.
module keypad_scanner #(
   parameter int SCAN_DIV     = 500,
   parameter int DEBOUNCE_CYC = 5000,
   parameter int STROBE_CYC   = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_row,
   output logic [2:0] o_col,
   output logic [3:0] o_number,
   output logic       o_key_strobe,
   output logic       o_key_err,
   output logic [1:0] o_state
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int STB_W = $clog2(STROBE_CYC + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_CYC);

   typedef enum logic [1:0] {
      S_SCAN     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_PRESSED  = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic [DIV_W-1:0] r_div;
   logic [DEB_W-1:0] r_deb;
   logic [STB_W-1:0] r_stb;
   logic [1:0]       r_col_idx;
   logic [1:0]       r_row_idx;
   logic [3:0]       r_row_pat;
   logic [3:0]       r_number;
   logic             r_key_err;

   logic [3:0]       w_low;
   logic [2:0]       w_low_cnt;
   logic             w_one_low;
   logic             w_multi_low;
   logic             w_all_high;
   logic [1:0]       w_row_enc;
   logic             w_match;
   logic             w_div_last;
   logic             w_deb_last;
   logic             w_stb_done;
   logic [1:0]       w_col_next;
   logic [3:0]       w_code;

   // Row decode: how many lines are pulled low and which one.
   always_comb begin
      w_low       = ~i_row;
      w_low_cnt   = {2'b00, w_low[0]} + {2'b00, w_low[1]} +
                    {2'b00, w_low[2]} + {2'b00, w_low[3]};
      w_one_low   = (w_low_cnt == 3'd1);
      w_multi_low = (w_low_cnt > 3'd1);
      w_all_high  = (i_row == 4'hF);
      w_match     = (i_row == r_row_pat);
      w_row_enc   = 2'd0;
      case (w_low)
         4'b0010: w_row_enc = 2'd1;
         4'b0100: w_row_enc = 2'd2;
         4'b1000: w_row_enc = 2'd3;
         default: w_row_enc = 2'd0;
      endcase
   end

   always_comb begin
      w_div_last = (r_div == DIV_LAST);
      w_deb_last = (r_deb == DEB_LAST);
      w_stb_done = (r_stb == STB_LAST);
      w_col_next = (r_col_idx == 2'd2) ? 2'd0 : r_col_idx + 2'd1;
   end

   // Rows 0-2 hold digits 1-9 in reading order; row 3 is '*', '0', '#'.
   always_comb begin
      w_code = 4'd0;
      if (r_row_idx != 2'd3) begin
         w_code = 4'(r_row_idx) * 4'd3 + 4'(r_col_idx) + 4'd1;
      end else begin
         case (r_col_idx)
            2'd0:    w_code = 4'd10;
            2'd1:    w_code = 4'd0;
            default: w_code = 4'd11;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_SCAN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_SCAN: begin
            if (w_div_last && w_one_low) begin
               w_next_state = S_DEBOUNCE;
            end
         end
         S_DEBOUNCE: begin
            if (!w_match) begin
               w_next_state = S_SCAN;
            end else if (w_deb_last) begin
               w_next_state = S_PRESSED;
            end
         end
         S_PRESSED: begin
            if (w_stb_done) begin
               w_next_state = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (w_all_high && w_deb_last) begin
               w_next_state = S_SCAN;
            end
         end
         default: w_next_state = S_SCAN;
      endcase
   end

   // Counters and captured key; every counter is cleared on entry to the state using it.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_div     <= '0;
         r_deb     <= '0;
         r_stb     <= '0;
         r_col_idx <= 2'd0;
         r_row_idx <= 2'd0;
         r_row_pat <= 4'hF;
         r_number  <= 4'd0;
         r_key_err <= 1'b0;
      end else begin
         r_key_err <= 1'b0;
         case (r_state)
            S_SCAN: begin
               if (w_div_last) begin
                  r_div <= '0;
                  if (w_one_low) begin
                     r_row_idx <= w_row_enc;
                     r_row_pat <= i_row;
                     r_deb     <= '0;
                  end else begin
                     r_col_idx <= w_col_next;
                     r_key_err <= w_multi_low;
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_DEBOUNCE: begin
               if (!w_match) begin
                  r_col_idx <= w_col_next;
                  r_div     <= '0;
               end else if (w_deb_last) begin
                  r_number <= w_code;
                  r_stb    <= '0;
               end else begin
                  r_deb <= r_deb + 1'b1;
               end
            end
            S_PRESSED: begin
               if (w_stb_done) begin
                  r_deb <= '0;
               end else begin
                  r_stb <= r_stb + 1'b1;
               end
            end
            S_RELEASE: begin
               if (!w_all_high) begin
                  r_deb <= '0;
               end else if (w_deb_last) begin
                  r_col_idx <= w_col_next;
                  r_div     <= '0;
               end else begin
                  r_deb <= r_deb + 1'b1;
               end
            end
            default: r_div <= '0;
         endcase
      end
   end

   // The first PRESSED cycle presents the new code with the strobe still low.
   always_comb begin
      o_col = 3'b110;
      case (r_col_idx)
         2'd1:    o_col = 3'b101;
         2'd2:    o_col = 3'b011;
         default: o_col = 3'b110;
      endcase
      o_key_strobe = (r_state == S_PRESSED) && (r_stb != '0);
      o_number     = r_number;
      o_key_err    = r_key_err;
      o_state      = r_state;
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows, a threaded
// behavioural model predicts every output cycle, and directed scenarios pin literals.
module tb_keypad_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CYC = 8;
   localparam int STROBE_CYC   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [2:0]  col;
   logic [3:0]  number;
   logic        key_strobe;
   logic        key_err;
   logic [1:0]  state;

   logic [11:0] keys = '0;

   int          vec_cnt = 0;
   int          err_cnt = 0;
   int          strobe_cnt = 0;
   int          err_pulse_cnt = 0;
   logic        prev_stb = 1'b0;

   logic [2:0]  m_col = 3'b110;
   logic [3:0]  m_number = 4'd0;
   logic        m_strobe = 1'b0;
   logic        m_err = 1'b0;
   logic [3:0]  exp_q[$];

   keypad_scanner #(
      .SCAN_DIV    (SCAN_DIV),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .STROBE_CYC  (STROBE_CYC)
   ) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_row       (row),
      .o_col       (col),
      .o_number    (number),
      .o_key_strobe(key_strobe),
      .o_key_err   (key_err),
      .o_state     (state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Keypad matrix: a closed key pulls its row low while its column is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (keys[r*3+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      vec_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [3:0] key_code(input int r, input int c);
      string lbl;
      byte   ch;
      lbl = "123456789*0#";
      ch  = lbl[r*3+c];
      if (ch == "*") return 4'd10;
      if (ch == "#") return 4'd11;
      return 4'(ch - "0");
   endfunction

   function automatic int zeros(input logic [3:0] r);
      int n = 0;
      for (int i = 0; i < 4; i++) if (!r[i]) n++;
      return n;
   endfunction

   function automatic int low_index(input logic [3:0] r);
      for (int i = 0; i < 4; i++) if (!r[i]) return i;
      return 0;
   endfunction

   function automatic logic [2:0] col_of(input int c);
      logic [2:0] v;
      v = 3'b111;
      v[c] = 1'b0;
      return v;
   endfunction

   // One clock period: row seen during the cycle, then the edge that ends it.
   task automatic step(output logic [3:0] r, output bit ab);
      ab = 1'b0;
      r  = 4'hF;
      @(negedge clk);
      if (rst) begin
         ab = 1'b1;
         return;
      end
      r = row;
      @(posedge clk);
      if (rst) ab = 1'b1;
      m_err = 1'b0;
   endtask

   task automatic model_run();
      logic [3:0] r;
      logic [3:0] pat;
      bit         ab;
      int         c, ri, n, run;
      c = 0;
      forever begin
         m_col = col_of(c);
         for (int k = 0; k < SCAN_DIV; k++) begin
            step(r, ab);
            if (ab) return;
         end
         n = zeros(r);
         if (n != 1) begin
            m_err = (n > 1);
            c = (c + 1) % 3;
            continue;
         end
         pat = r;
         ri  = low_index(r);
         run = 0;
         while (run < DEBOUNCE_CYC) begin
            step(r, ab);
            if (ab) return;
            if (r != pat) break;
            run++;
         end
         if (run < DEBOUNCE_CYC) begin
            c = (c + 1) % 3;
            continue;
         end
         m_number = key_code(ri, c);
         exp_q.push_back(m_number);
         for (int s = 0; s <= STROBE_CYC; s++) begin
            step(r, ab);
            if (ab) return;
            m_strobe = (s < STROBE_CYC);
         end
         run = 0;
         while (run < DEBOUNCE_CYC) begin
            step(r, ab);
            if (ab) return;
            run = (r == 4'hF) ? run + 1 : 0;
         end
         c = (c + 1) % 3;
      end
   endtask

   initial begin : model_proc
      forever begin
         wait (!rst);
         model_run();
         m_col    = 3'b110;
         m_number = 4'd0;
         m_strobe = 1'b0;
         m_err    = 1'b0;
      end
   end

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      if (rst) begin
         check("rst_col", int'(col), 6);
         check("rst_number", int'(number), 0);
         check("rst_strobe", int'(key_strobe), 0);
         check("rst_err", int'(key_err), 0);
         exp_q.delete();
      end else begin
         check("col", int'(col), int'(m_col));
         check("number", int'(number), int'(m_number));
         check("strobe", int'(key_strobe), int'(m_strobe));
         check("key_err", int'(key_err), int'(m_err));
         if (key_err) err_pulse_cnt++;
         if (key_strobe && !prev_stb) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
               check("strobe_unexpected", 1, 0);
            end else begin
               check("strobe_code", int'(number), int'(exp_q.pop_front()));
            end
         end
      end
      prev_stb = key_strobe;
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int k, input int hold);
      keys[k] = 1'b1;
      cycles(hold);
      keys[k] = 1'b0;
   endtask

   task automatic bounce(input int k, input int reps, input int low_n, input int high_n);
      repeat (reps) begin
         keys[k] = 1'b1;
         cycles(low_n);
         keys[k] = 1'b0;
         cycles(high_n);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int  s0, e0, k, k2, found;
      cycles(3);
      @(posedge clk);
      #1 rst = 1'b0;
      check("init_col", int'(col), 6);
      check("init_number", int'(number), 0);
      check("init_strobe", int'(key_strobe), 0);
      cycles(20);

      // Key '2' (row 0, column 1).
      s0 = strobe_cnt;
      press(1, 60);
      cycles(40);
      check("k2_strobes", strobe_cnt - s0, 1);
      check("k2_number", int'(number), 2);

      // '*' then '#'.
      s0 = strobe_cnt;
      press(9, 60);
      cycles(40);
      check("star_number", int'(number), 10);
      press(11, 60);
      cycles(40);
      check("hash_number", int'(number), 11);
      check("star_hash_strobes", strobe_cnt - s0, 2);

      // Bouncing '5' never holds long enough, then a stable press.
      s0 = strobe_cnt;
      bounce(4, 10, 3, 1);
      check("bounce_strobes", strobe_cnt - s0, 0);
      press(4, 40);
      cycles(40);
      check("bounce_then_stable", strobe_cnt - s0, 1);
      check("k5_number", int'(number), 5);

      // Two rows low in column 0: one error pulse, no key.
      s0 = strobe_cnt;
      e0 = err_pulse_cnt;
      keys[0] = 1'b1;
      keys[3] = 1'b1;
      cycles(12);
      keys[0] = 1'b0;
      keys[3] = 1'b0;
      cycles(20);
      check("multi_err_pulses", err_pulse_cnt - e0, 1);
      check("multi_strobes", strobe_cnt - s0, 0);

      // Long hold of '9' with a second key and a bouncy release.
      s0 = strobe_cnt;
      keys[8] = 1'b1;
      cycles(300);
      press(6, 100);
      cycles(600);
      repeat (4) begin
         keys[8] = 1'b0;
         cycles(5);
         keys[8] = 1'b1;
         cycles(1);
      end
      keys[8] = 1'b0;
      cycles(40);
      check("hold_strobes", strobe_cnt - s0, 1);
      check("hold_number", int'(number), 9);

      // Randomised presses, bounces and chords.
      for (int it = 0; it < 30; it++) begin
         k = $urandom_range(0, 11);
         if ($urandom_range(0, 2) == 0) bounce(k, $urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(1, 3));
         keys[k] = 1'b1;
         if ($urandom_range(0, 3) == 0) begin
            k2 = $urandom_range(0, 11);
            keys[k2] = 1'b1;
         end
         cycles($urandom_range(1, 50));
         keys = '0;
         cycles($urandom_range(1, 40));
      end
      cycles(40);

      // Reset in the second strobe cycle aborts the strobe at once.
      keys[2] = 1'b1;
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (key_strobe) begin
            found = 1;
            break;
         end
      end
      check("strobe_wait", found, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_strobe", int'(key_strobe), 0);
      check("abort_number", int'(number), 0);
      check("abort_col", int'(col), 6);
      keys[2] = 1'b0;
      cycles(3);
      @(posedge clk);
      #1 rst = 1'b0;
      s0 = strobe_cnt;
      cycles(40);
      check("abort_no_strobe", strobe_cnt - s0, 0);
      check("abort_number_idle", int'(number), 0);

      check("exp_q_drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 500: clock cycles each column is driven before rows are sampled.
REQ-002 Parameter DEBOUNCE_CYC, default 5000: consecutive stable cycles required to accept a press or a release.
REQ-003 Parameter STROBE_CYC, default 4: width of key_strobe in clock cycles.
REQ-004 clk  in  1  system clock, single clock domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 row  in  4  keypad row lines, active-low (pulled up externally), already synchronised.
REQ-007 col  out  3  keypad column drive, active-low one-cold.
REQ-008 number  out  4  code of last accepted key; feeds the display stage number input.
REQ-009 key_strobe  out  1  high for STROBE_CYC cycles per accepted key; feeds the display stage key clock.
REQ-010 key_err  out  1  one-cycle pulse when more than one row is low in a sample.

Function
REQ-011 Key map (row,col): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#; col0 is leftmost.
REQ-012 Codes: digits 0-9 -> 4'd0-4'd9; '*' -> 4'd10; '#' -> 4'd11; codes 12-15 are never produced.
REQ-013 FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-014 SCAN: col cycles 3'b110 -> 3'b101 -> 3'b011 -> 3'b110; each column is held exactly SCAN_DIV cycles.
REQ-015 SCAN: row is sampled on the last cycle of each column period; all-high -> advance column.
REQ-016 SCAN: exactly one row low -> capture row index and column index, freeze col, enter DEBOUNCE next cycle.
REQ-017 SCAN: two or more rows low -> pulse key_err for one cycle, ignore the sample, advance column.
REQ-018 DEBOUNCE: the counter clears on entry; any cycle with row != captured pattern -> return to SCAN on the next column.
REQ-019 DEBOUNCE: match held for DEBOUNCE_CYC consecutive cycles -> enter PRESSED.
REQ-020 On entry to PRESSED, number loads the mapped code; key_strobe rises the following cycle.
REQ-021 number stays stable from one cycle before key_strobe rises until the next accepted key.
REQ-022 key_strobe is high exactly STROBE_CYC cycles; the FSM then enters RELEASE.
REQ-023 RELEASE: col stays frozen; requires row all-high for DEBOUNCE_CYC consecutive cycles, any low restarts the count.
REQ-024 RELEASE: count complete -> SCAN, starting at the column after the captured one.
REQ-025 There is no auto-repeat: a held key produces exactly one strobe.
REQ-026 A second key pressed while in PRESSED or RELEASE is ignored until full release.
REQ-027 All counters size to their parameters and never wrap; the column index wraps only 2 -> 0.

Reset
REQ-028 Reset values: state SCAN, col 3'b110, number 4'd0, key_strobe 0, key_err 0, all counters 0.
REQ-029 Reset asserted mid-operation aborts any press immediately; a pending or partial strobe is never completed.

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8, STROBE_CYC=4)
REQ-030 Hold row=4'b1110 while col=3'b101, clean press -> number=4'd2, then key_strobe high 4 cycles, once only.
REQ-031 Press r3/c0 then release, then r3/c2 -> number 4'd10 with strobe, then 4'd11 with strobe; exactly two strobes.
REQ-032 Bounce: row low 3 cycles, high 1, repeated -> no strobe; then a stable low of 8 cycles -> one strobe.
REQ-033 Rows 4'b1100 low together during a sample -> key_err pulse, no strobe, col advances.
REQ-034 Key held 1000 cycles -> exactly one strobe; release bounce shorter than 8 cycles -> no new strobe.
REQ-035 Assert reset in the second strobe cycle -> key_strobe=0, number=0, col=3'b110 within the same cycle.
